// File: rtl/if_stage_redirect_if.sv
// Fetch-stage bundle: the hazard/EX controls and imem data going in, and the
// IF/ID register plus status coming out.
interface if_stage_redirect_if;
  logic        stall;
  logic        switch_branch;
  logic [63:0] branch_target;
  logic [31:0] instr_in;
  logic [63:0] pc_out;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        flush_idex;
  logic [15:0] redirect_count;
  logic        misalign_err;

  modport master (
    output stall, switch_branch, branch_target, instr_in,
    input  pc_out, ifid_pc, ifid_instr, ifid_valid, flush_idex,
           redirect_count, misalign_err
  );

  modport slave (
    input  stall, switch_branch, branch_target, instr_in,
    output pc_out, ifid_pc, ifid_instr, ifid_valid, flush_idex,
           redirect_count, misalign_err
  );
endinterface

// File: rtl/if_stage_redirect.sv
// Instruction-fetch stage with EX-stage branch redirect. After each redirect it
// spends one FLUSH cycle in which further redirects are ignored.
module if_stage_redirect (
  input  logic                 clk,
  input  logic                 reset,
  if_stage_redirect_if.slave   bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] redirect_count_q, redirect_count_d;
  logic        misalign_q, misalign_d;
  logic        accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= RUN;
      pc_q             <= '0;
      ifid_pc_q        <= '0;
      ifid_instr_q     <= NOP;
      ifid_valid_q     <= 1'b0;
      redirect_count_q <= '0;
      misalign_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      ifid_pc_q        <= ifid_pc_d;
      ifid_instr_q     <= ifid_instr_d;
      ifid_valid_q     <= ifid_valid_d;
      redirect_count_q <= redirect_count_d;
      misalign_q       <= misalign_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ifid_pc_d        = ifid_pc_q;
    ifid_instr_d     = ifid_instr_q;
    ifid_valid_d     = ifid_valid_q;
    redirect_count_d = redirect_count_q;
    misalign_d       = misalign_q;
    accept           = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.switch_branch) begin
          // Redirect outranks stall: the EX-stage branch must never be lost.
          accept           = 1'b1;
          state_d          = FLUSH;
          pc_d             = {bus.branch_target[63:2], 2'b00};
          ifid_pc_d        = '0;
          ifid_instr_d     = NOP;
          ifid_valid_d     = 1'b0;
          redirect_count_d = (redirect_count_q == '1) ? redirect_count_q
                                                      : redirect_count_q + 16'd1;
          misalign_d       = misalign_q | (|bus.branch_target[1:0]);
        end else if (!bus.stall) begin
          pc_d         = pc_q + 64'd4;
          ifid_pc_d    = pc_q;
          ifid_instr_d = bus.instr_in;
          ifid_valid_d = 1'b1;
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          state_d      = RUN;
          pc_d         = pc_q + 64'd4;
          ifid_pc_d    = pc_q;
          ifid_instr_d = bus.instr_in;
          ifid_valid_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // state_q is already RUN while reset is high, so gate explicitly.
  assign bus.flush_idex     = accept & ~reset;
  assign bus.pc_out         = pc_q;
  assign bus.ifid_pc        = ifid_pc_q;
  assign bus.ifid_instr     = ifid_instr_q;
  assign bus.ifid_valid     = ifid_valid_q;
  assign bus.redirect_count = redirect_count_q;
  assign bus.misalign_err   = misalign_q;
endmodule

// File: tb/tb_if_stage_redirect.sv
// Directed bench for if_stage_redirect: a behavioural fetch model compared on
// every falling edge, plus literal expectations at key points.
module tb_if_stage_redirect;
  logic clk = 1'b0;
  logic reset = 1'b0;
  if_stage_redirect_if bus ();

  int n_total = 0;
  int n_pass  = 0;
  bit run_cmp = 1'b0;

  // Behavioural model state
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid, m_mis, m_shadow;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_fn(logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  assign bus.instr_in = instr_fn(bus.pc_out);

  if_stage_redirect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = '0; m_ifpc = '0; m_instr = 32'h13; m_valid = 1'b0;
    m_cnt = '0; m_mis = 1'b0; m_shadow = 1'b0;
  endtask

  // One clock edge of the fetch stage as the requirements describe it.
  task automatic model_step();
    if (reset) model_reset();
    else if (!m_shadow && bus.switch_branch) begin
      m_shadow = 1'b1;
      m_pc     = bus.branch_target & ~64'd3;
      m_ifpc   = '0;
      m_instr  = 32'h13;
      m_valid  = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (bus.branch_target[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!bus.stall) begin
      m_shadow = 1'b0;
      m_ifpc   = m_pc;
      m_instr  = instr_fn(m_pc);
      m_valid  = 1'b1;
      m_pc     = m_pc + 64'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("pc_out",     bus.pc_out,         m_pc);
      check("ifid_pc",    bus.ifid_pc,        m_ifpc);
      check("ifid_instr", 64'(bus.ifid_instr), 64'(m_instr));
      check("ifid_valid", 64'(bus.ifid_valid), 64'(m_valid));
      check("count",      64'(bus.redirect_count), 64'(m_cnt));
      check("misalign",   64'(bus.misalign_err), 64'(m_mis));
      check("flush_idex", 64'(bus.flush_idex),
            64'(!reset && !m_shadow && bus.switch_branch));
    end
  end

  initial begin
    bus.stall = 1'b0; bus.switch_branch = 1'b0; bus.branch_target = '0;
    #1 reset = 1'b1;
    model_reset();
    run_cmp = 1'b1;
    #2;
    check("rst_pc",    bus.pc_out, 64'd0);
    check("rst_instr", 64'(bus.ifid_instr), 64'h13);
    check("rst_valid", 64'(bus.ifid_valid), 64'd0);
    check("rst_cnt",   64'(bus.redirect_count), 64'd0);
    @(posedge clk); model_step(); #1;
    reset = 1'b0;

    tick(); check("f1_pc", bus.pc_out, 64'd4); check("f1_ifpc", bus.ifid_pc, 64'd0);
            check("f1_valid", 64'(bus.ifid_valid), 64'd1);
    tick(); check("f2_pc", bus.pc_out, 64'd8); check("f2_ifpc", bus.ifid_pc, 64'd4);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc_out, 64'd8);
      check("stall_ifpc", bus.ifid_pc, 64'd4);
      check("stall_instr", 64'(bus.ifid_instr), 64'(instr_fn(64'd4)));
    end
    bus.stall = 1'b0;
    tick(); check("rel_pc", bus.pc_out, 64'd12); check("rel_ifpc", bus.ifid_pc, 64'd8);
    tick(); check("f16_pc", bus.pc_out, 64'd16);

    bus.switch_branch = 1'b1; bus.branch_target = 64'h100;
    #1 check("redir_flush", 64'(bus.flush_idex), 64'd1);
    tick();
    check("redir_pc", bus.pc_out, 64'h100);
    check("redir_valid", 64'(bus.ifid_valid), 64'd0);
    check("redir_instr", 64'(bus.ifid_instr), 64'h13);
    check("redir_cnt", 64'(bus.redirect_count), 64'd1);
    #1 check("flushcyc_flush", 64'(bus.flush_idex), 64'd0);
    tick(); bus.switch_branch = 1'b0;
    check("post_ifpc", bus.ifid_pc, 64'h100);
    check("post_pc", bus.pc_out, 64'h104);
    check("post_cnt", 64'(bus.redirect_count), 64'd1);

    bus.switch_branch = 1'b1; bus.stall = 1'b1; bus.branch_target = 64'h200;
    tick(); bus.switch_branch = 1'b0;
    check("stredir_pc", bus.pc_out, 64'h200);
    check("stredir_cnt", 64'(bus.redirect_count), 64'd2);
    tick(); check("flushhold_pc", bus.pc_out, 64'h200);
    bus.stall = 1'b0;
    tick(); check("flushrel_pc", bus.pc_out, 64'h204);

    bus.switch_branch = 1'b1; bus.branch_target = 64'h102;
    tick(); bus.switch_branch = 1'b0;
    check("mis_pc", bus.pc_out, 64'h100);
    check("mis_flag", 64'(bus.misalign_err), 64'd1);
    tick(); tick();
    check("mis_sticky", 64'(bus.misalign_err), 64'd1);
    check("mis_pc2", bus.pc_out, 64'h108);

    force dut.redirect_count_q = 16'hFFFE;
    #1 release dut.redirect_count_q;
    m_cnt = 16'hFFFE;
    bus.switch_branch = 1'b1; bus.branch_target = 64'h0;
    tick(); bus.switch_branch = 1'b0;
    check("sat_cnt1", 64'(bus.redirect_count), 64'hFFFF);
    tick();
    bus.switch_branch = 1'b1; bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); bus.switch_branch = 1'b0;
    check("sat_cnt2", 64'(bus.redirect_count), 64'hFFFF);
    check("top_pc", bus.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_pc", bus.pc_out, 64'd0);
    check("wrap_ifpc", bus.ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    bus.switch_branch = 1'b1; bus.branch_target = 64'h300;
    tick(); bus.switch_branch = 1'b0;
    check("pre_rst_pc", bus.pc_out, 64'h300);
    #2 reset = 1'b1; bus.switch_branch = 1'b1;
    model_reset();
    #1;
    check("arst_pc", bus.pc_out, 64'd0);
    check("arst_ifpc", bus.ifid_pc, 64'd0);
    check("arst_instr", 64'(bus.ifid_instr), 64'h13);
    check("arst_valid", 64'(bus.ifid_valid), 64'd0);
    check("arst_cnt", 64'(bus.redirect_count), 64'd0);
    check("arst_mis", 64'(bus.misalign_err), 64'd0);
    check("arst_flush", 64'(bus.flush_idex), 64'd0);
    tick();
    reset = 1'b0; bus.switch_branch = 1'b0;
    tick();
    check("after_pc", bus.pc_out, 64'd4);
    check("after_ifpc", bus.ifid_pc, 64'd0);
    check("after_instr", 64'(bus.ifid_instr), 64'(instr_fn(64'd0)));
    check("after_valid", 64'(bus.ifid_valid), 64'd1);
    tick(); check("after_pc2", bus.pc_out, 64'd8);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/if_stage_redirect.md
IF_STAGE_REDIRECT -- requirements
Module: if_stage_redirect

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  async active-high reset.
REQ-004 stall  in  1  hazard-unit hold of PC and IF/ID register.
REQ-005 switch_branch  in  1  EX-stage branch-taken resolution.
REQ-006 branch_target  in  64  EX-stage branch target address.
REQ-007 instr_in  in  32  instruction-memory read data, combinational at pc_out.
REQ-008 pc_out  out  64  current fetch PC.
REQ-009 ifid_pc  out  64  IF/ID registered PC.
REQ-010 ifid_instr  out  32  IF/ID registered instruction.
REQ-011 ifid_valid  out  1  IF/ID holds a real instruction.
REQ-012 flush_idex  out  1  combinational request to bubble ID/EX this cycle.
REQ-013 redirect_count  out  16  saturating count of accepted redirects.
REQ-014 misalign_err  out  1  sticky flag: redirect target not word-aligned.

Function
REQ-015 SHALL implement a two-state FSM: RUN, FLUSH; the reset state is RUN.
REQ-016 In RUN with switch_branch=0 and stall=0, it SHALL set pc<=pc+4 (64-bit wrap-around modulo 2^64), ifid_pc<=pc, ifid_instr<=instr_in and ifid_valid<=1.
REQ-017 In RUN with switch_branch=0 and stall=1, pc, ifid_pc, ifid_instr, ifid_valid, state and counters SHALL hold.
REQ-018 In RUN with switch_branch=1, the block SHALL accept the redirect regardless of stall (the redirect has priority over stall).
REQ-019 An accepted redirect SHALL update pc<={branch_target[63:2],2'b00}.
REQ-020 An accepted redirect SHALL load IF/ID with a bubble: ifid_instr<=32'h00000013 (NOP), ifid_valid<=0, ifid_pc<=0.
REQ-021 An accepted redirect SHALL move the FSM to FLUSH.
REQ-022 flush_idex SHALL equal 1 exactly when state=RUN and switch_branch=1; it is 0 otherwise, including during reset.
REQ-023 An accepted redirect SHALL increment redirect_count, saturating at 16'hFFFF with no wrap-around.
REQ-024 An accepted redirect with branch_target[1:0]!=0 SHALL set misalign_err to 1; it stays 1 until reset.
REQ-025 In FLUSH, switch_branch SHALL be ignored, because the EX-stage occupant is a bubble.
REQ-026 In FLUSH with stall=0, the block SHALL fetch normally as in REQ-016 and return to RUN.
REQ-027 In FLUSH with stall=1, all state SHALL hold and the FSM SHALL stay in FLUSH.
REQ-028 pc_out SHALL present the PC register directly; fetch latency is one cycle from pc_out to IF/ID.
REQ-029 No redirect SHALL ever be dropped in RUN; back-to-back redirects are impossible by construction (FLUSH follows every redirect).

Reset
REQ-030 While reset=1, asynchronously and independent of clk, the block SHALL force: pc=0, state=RUN, ifid_pc=0, ifid_instr=32'h00000013, ifid_valid=0, redirect_count=0, misalign_err=0.
REQ-031 Reset asserted mid-FLUSH or mid-stall SHALL abandon the operation; the first edge after deassertion fetches from address 0.
REQ-032 Deassertion SHALL be sampled on clk; the first rising edge with reset=0 performs a normal RUN step.

Verification
REQ-033 Bench: reset, then 3 cycles idle with instr_in=mem[pc] -> pc_out 0,4,8,12; ifid_pc 0,4,8; ifid_valid=1 from the first edge.
REQ-034 Bench: at pc=16, switch_branch=1, target=0x100 -> flush_idex=1 that cycle; next edge pc=0x100, ifid_valid=0, ifid_instr=0x13, redirect_count=1; the following edge ifid_pc=0x100.
REQ-035 Bench: switch_branch=1 and stall=1 together in RUN -> redirect taken (pc=target); a switch_branch pulse in the FLUSH cycle -> ignored, flush_idex=0, count unchanged.
REQ-036 Bench: stall=1 for 3 cycles at pc=8 -> pc_out, ifid_* and count constant; release -> pc=12 next edge.
REQ-037 Bench: target=0x102 -> pc=0x100, misalign_err=1 and it persists; preload count 0xFFFF plus a redirect -> stays 0xFFFF; pc=0xFFFF_FFFF_FFFF_FFFC plus a normal fetch -> pc=0.
REQ-038 Bench: assert reset asynchronously mid-FLUSH (between edges) -> outputs take reset values immediately, with no clk edge.
